// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm
//   Multi-cycle LC-3 control unit. Sequences fetch / decode / execute and
//   decodes every datapath control pin from the current state, IR and NZP.
//   Memory states wait on memReady and give up into HALT (with memError)
//   after MEM_TIMEOUT cycles; MEM_TIMEOUT = 0 waits forever.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   IR, N, Z, P       instruction register and condition codes from datapath
//   memReady          memory finished the current access this cycle
//   aluControl        0 ADD, 1 AND, 2 NOT, 3 PASS A
//   enaALU/MARM/MDR/PC  bus drivers (at most one high per state)
//   selMAR, selEAB1, selEAB2, selPC, selMDR  datapath mux selects
//   ldPC, ldIR, ldMAR, ldMDR                 register loads
//   SR0, SR1, DR      register-file addresses
//   regWE, memWE      register-file / memory write enables
//   halted, memError  HALT state, and HALT reached through a timeout
module lc3_control_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    input  logic        memReady,
    output logic [1:0]  aluControl,
    output logic        enaALU,
    output logic        enaMARM,
    output logic        enaMDR,
    output logic        enaPC,
    output logic        selMAR,
    output logic        selEAB1,
    output logic [1:0]  selEAB2,
    output logic [1:0]  selPC,
    output logic        ldPC,
    output logic        ldIR,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        selMDR,
    output logic [2:0]  SR0,
    output logic [2:0]  SR1,
    output logic [2:0]  DR,
    output logic        regWE,
    output logic        memWE,
    output logic        halted,
    output logic        memError
);

    localparam logic [3:0] S_RST  = 4'd0;
    localparam logic [3:0] S_F1   = 4'd1;
    localparam logic [3:0] S_F2   = 4'd2;
    localparam logic [3:0] S_F3   = 4'd3;
    localparam logic [3:0] S_DEC  = 4'd4;
    localparam logic [3:0] S_EXA  = 4'd5;
    localparam logic [3:0] S_BR   = 4'd6;
    localparam logic [3:0] S_JMP  = 4'd7;
    localparam logic [3:0] S_LEA  = 4'd8;
    localparam logic [3:0] S_LD1  = 4'd9;
    localparam logic [3:0] S_LD2  = 4'd10;
    localparam logic [3:0] S_LD3  = 4'd11;
    localparam logic [3:0] S_ST1  = 4'd12;
    localparam logic [3:0] S_ST2  = 4'd13;
    localparam logic [3:0] S_ST3  = 4'd14;
    localparam logic [3:0] S_HALT = 4'd15;

    localparam logic [8:0] TIMEOUT = 9'(MEM_TIMEOUT);

    logic [3:0] state, state_next;
    logic [7:0] wait_cnt, wait_cnt_next;
    logic       mem_error_q;
    logic       in_wait, timeout_hit, br_taken;
    logic [3:0] opcode;
    logic       unused_ir;

    assign opcode    = IR[15:12];
    assign unused_ir = ^IR[5:3];
    assign br_taken  = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);

    // The counter is held at zero outside the wait states, so it is
    // already clear on entry to F2, LD2 or ST3. memReady wins over a
    // timeout reached in the same cycle.
    always_comb begin
        in_wait       = (state == S_F2) || (state == S_LD2) || (state == S_ST3);
        timeout_hit   = in_wait && !memReady && (MEM_TIMEOUT != 0) &&
                        (({1'b0, wait_cnt} + 9'd1) == TIMEOUT);
        wait_cnt_next = (in_wait && !memReady) ? wait_cnt + 8'd1 : '0;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RST:  state_next = S_F1;
            S_F1:   state_next = S_F2;
            S_F2:   state_next = timeout_hit ? S_HALT : (memReady ? S_F3 : S_F2);
            S_F3:   state_next = S_DEC;
            S_DEC: begin
                case (opcode)
                    4'b0001, 4'b0101, 4'b1001: state_next = S_EXA;
                    4'b0000:                   state_next = S_BR;
                    4'b1100:                   state_next = S_JMP;
                    4'b0010, 4'b0110:          state_next = S_LD1;
                    4'b0011, 4'b0111:          state_next = S_ST1;
                    4'b1110:                   state_next = S_LEA;
                    4'b1111:                   state_next = S_HALT;
                    default:                   state_next = S_F1;
                endcase
            end
            S_EXA, S_BR, S_JMP, S_LEA, S_LD3: state_next = S_F1;
            S_LD1:  state_next = S_LD2;
            S_LD2:  state_next = timeout_hit ? S_HALT : (memReady ? S_LD3 : S_LD2);
            S_ST1:  state_next = S_ST2;
            S_ST2:  state_next = S_ST3;
            S_ST3:  state_next = timeout_hit ? S_HALT : (memReady ? S_F1 : S_ST3);
            S_HALT: state_next = S_HALT;
            default: state_next = S_RST;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_RST;
            wait_cnt    <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (timeout_hit)
                mem_error_q <= 1'b1;
        end
    end

    always_comb begin
        aluControl = 2'd0;
        enaALU     = 1'b0;
        enaMARM    = 1'b0;
        enaMDR     = 1'b0;
        enaPC      = 1'b0;
        selMAR     = 1'b0;
        selEAB1    = 1'b0;
        selEAB2    = 2'd0;
        selPC      = 2'd0;
        ldPC       = 1'b0;
        ldIR       = 1'b0;
        ldMAR      = 1'b0;
        ldMDR      = 1'b0;
        selMDR     = 1'b0;
        SR0        = 3'd0;
        SR1        = 3'd0;
        DR         = 3'd0;
        regWE      = 1'b0;
        memWE      = 1'b0;
        halted     = 1'b0;
        memError   = 1'b0;
        case (state)
            S_F1: begin
                enaPC = 1'b1;
                ldMAR = 1'b1;
                ldPC  = 1'b1;
            end
            S_F2, S_LD2: begin
                selMDR = 1'b1;
                ldMDR  = memReady;
            end
            S_F3: begin
                enaMDR = 1'b1;
                ldIR   = 1'b1;
            end
            S_EXA: begin
                SR0    = IR[8:6];
                SR1    = IR[2:0];
                DR     = IR[11:9];
                enaALU = 1'b1;
                regWE  = 1'b1;
                case (opcode)
                    4'b0101: aluControl = 2'd1;
                    4'b1001: aluControl = 2'd2;
                    default: aluControl = 2'd0;
                endcase
            end
            S_BR: begin
                if (br_taken) begin
                    ldPC    = 1'b1;
                    selPC   = 2'd1;
                    selEAB2 = 2'd2;
                end
            end
            S_JMP: begin
                SR0        = IR[8:6];
                aluControl = 2'd3;
                enaALU     = 1'b1;
                ldPC       = 1'b1;
                selPC      = 2'd2;
            end
            S_LEA: begin
                DR      = IR[11:9];
                selEAB2 = 2'd2;
                enaMARM = 1'b1;
                regWE   = 1'b1;
            end
            S_LD1, S_ST1: begin
                enaMARM = 1'b1;
                ldMAR   = 1'b1;
                // IR[14] separates base-relative LDR/STR from PC-relative LD/ST
                if (IR[14]) begin
                    selEAB1 = 1'b1;
                    selEAB2 = 2'd1;
                    SR0     = IR[8:6];
                end else begin
                    selEAB2 = 2'd2;
                end
            end
            S_LD3: begin
                enaMDR = 1'b1;
                DR     = IR[11:9];
                regWE  = 1'b1;
            end
            S_ST2: begin
                SR0        = IR[11:9];
                aluControl = 2'd3;
                enaALU     = 1'b1;
                ldMDR      = 1'b1;
            end
            S_ST3: memWE = 1'b1;
            S_HALT: begin
                halted   = 1'b1;
                memError = mem_error_q;
            end
            default: ;
        endcase
    end

endmodule
